// File: rtl/prog_loader.sv
// Byte-stream program loader: frames a length-prefixed, XOR-checked image
// into instruction memory and holds the CPU until the image verifies.
module prog_loader #(
    parameter int N     = 16,
    parameter int DEPTH = 256,
    parameter int A     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         start,
    output logic [A-1:0] mem_addr,
    output logic [N-1:0] mem_data,
    output logic         mem_we,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [CW-1:0]   idx_q, idx_d;
    logic [7:0]      chk_q, chk_d;
    logic [7:0]      hi_q, hi_d;
    logic            we_q, we_d;
    logic [A-1:0]    addr_q, addr_d;
    logic [N-1:0]    data_q, data_d;
    logic            hold_q, hold_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            xfer;
    logic [15:0]     len;
    logic [CW-1:0]   idx_inc;

    assign in_ready = (state_q != DONE) && (state_q != ERROR);
    assign xfer     = in_valid && in_ready;
    assign len      = {hi_q, in_data};
    assign idx_inc  = idx_q + CW'(1);

    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign error    = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LEN_HI;
            cnt_q   <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            LEN_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    cnt_d = len;
                    if (len > 16'(DEPTH)) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (len == 16'd0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    chk_d   = chk_q ^ in_data;
                    we_d    = 1'b1;
                    addr_d  = idx_q[A-1:0];
                    data_d  = {hi_q, in_data};
                    idx_d   = idx_inc;
                    state_d = (16'(idx_inc) < cnt_q) ? DATA_HI : CHECK;
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE, ERROR: begin
                // Restart keeps the last memory-port values; only control resets
                if (start) begin
                    state_d = LEN_HI;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    chk_d   = '0;
                end
            end
            default: state_d = LEN_HI;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: fixed frames with hand-computed
// write sequences and final status.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        start = 1'b0;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int total = 0;
    int passed = 0;

    logic [7:0]  wa [16];
    logic [15:0] wd [16];
    int          wc = 0;
    int          base = 0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always @(negedge clk) begin
        if (mem_we && wc < 16) begin
            wa[wc] = mem_addr;
            wd[wc] = mem_data;
            wc = wc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic send_frame3(input logic [7:0] chk, input bit gaps);
        logic [7:0] f [9];
        f = '{8'h00, 8'h03, 8'h80, 8'h05, 8'h00, 8'h01,
              8'hB0, 8'h06, 8'h00};
        f[8] = chk;
        for (int i = 0; i < 9; i++) begin
            send(f[i]);
            if (gaps) idle();
        end
        idle();
    endtask

    task automatic check_frame3(input string tag);
        check({tag, ".wcount"}, wc - base, 3);
        check({tag, ".a0"}, wa[base],     8'd0);
        check({tag, ".d0"}, wd[base],     16'h8005);
        check({tag, ".a1"}, wa[base + 1], 8'd1);
        check({tag, ".d1"}, wd[base + 1], 16'h0001);
        check({tag, ".a2"}, wa[base + 2], 8'd2);
        check({tag, ".d2"}, wd[base + 2], 16'hB006);
    endtask

    task automatic check_status(input string tag, input logic d,
                                input logic e, input logic h,
                                input logic r);
        check({tag, ".done"},     done,     d);
        check({tag, ".error"},    error,    e);
        check({tag, ".cpu_hold"}, cpu_hold, h);
        check({tag, ".in_ready"}, in_ready, r);
    endtask

    initial begin
        // reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        settle();
        check("rst.mem_we",   mem_we,   1'b0);
        check("rst.mem_addr", mem_addr, 8'd0);
        check("rst.mem_data", mem_data, 16'd0);
        check_status("rst", 1'b0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;

        // 3-word frame, payload XOR = 80^05^00^01^B0^06 = 32
        settle();
        base = wc;
        send_frame3(8'h32, 1'b0);
        settle();
        check_frame3("ok3");
        check_status("ok3", 1'b1, 1'b0, 1'b0, 1'b0);
        check("ok3.hold_addr", mem_addr, 8'd2);
        check("ok3.hold_data", mem_data, 16'hB006);

        // same frame, bad checksum
        pulse_start();
        check_status("restart", 1'b0, 1'b0, 1'b1, 1'b1);
        base = wc;
        send_frame3(8'h34, 1'b0);
        settle();
        check_frame3("bad3");
        check_status("bad3", 1'b0, 1'b1, 1'b1, 1'b0);

        // over-length frame: 0x0101 > 256
        pulse_start();
        base = wc;
        send(8'h01);
        send(8'h01);
        idle();
        settle();
        check("long.wcount", wc - base, 0);
        check_status("long", 1'b0, 1'b1, 1'b1, 1'b0);
        pulse_start();
        base = wc;
        send(8'h00);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        send(8'h26);
        idle();
        settle();
        check("one.wcount", wc - base, 1);
        check("one.a0", wa[base], 8'd0);
        check("one.d0", wd[base], 16'h1234);
        check_status("one", 1'b1, 1'b0, 1'b0, 1'b0);

        // zero-length frame
        pulse_start();
        base = wc;
        send(8'h00);
        send(8'h00);
        send(8'h00);
        idle();
        settle();
        check("zero.wcount", wc - base, 0);
        check_status("zero", 1'b1, 1'b0, 1'b0, 1'b0);

        // in_valid toggling every cycle
        pulse_start();
        base = wc;
        send_frame3(8'h32, 1'b1);
        settle();
        check_frame3("gap3");
        check_status("gap3", 1'b1, 1'b0, 1'b0, 1'b0);

        // reset in mid-load after 5 bytes (one word already written)
        pulse_start();
        base = wc;
        send(8'h00);
        send(8'h03);
        send(8'h80);
        send(8'h05);
        send(8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        settle();
        check("mid.wcount", wc - base, 1);
        check("mid.mem_we",   mem_we,   1'b0);
        check("mid.mem_addr", mem_addr, 8'd0);
        check("mid.mem_data", mem_data, 16'd0);
        check_status("mid", 1'b0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        settle();
        base = wc;
        send_frame3(8'h32, 1'b0);
        settle();
        check_frame3("post");
        check_status("post", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
